// File: rtl/hazard_tnew_pipe_pkg.sv
// hazard_tnew_pipe_pkg: shared widths, Tnew classes, stage slice type and ageing helper
package hazard_tnew_pipe_pkg;
  localparam int REG_W = 5;
  localparam int TNEW_W = 2;
  typedef logic [TNEW_W-1:0] tnew_t;
  localparam tnew_t TNEW_ZERO = 2'd0;
  localparam tnew_t TNEW_ALU = 2'd1;
  localparam tnew_t TNEW_LOAD = 2'd2;
  typedef struct packed {
    logic [REG_W-1:0] write_reg;
    logic reg_write;
    tnew_t t_new;
  } stage_t;
  localparam stage_t BUBBLE = '0;
  function automatic tnew_t tnew_age(tnew_t t);
    return (t == TNEW_ZERO) ? TNEW_ZERO : t - 1'b1;
  endfunction
endpackage

// File: rtl/hazard_tnew_pipe_if.sv
// hazard_tnew_pipe_if: D-side tags in, stage-tagged operands out toward the stall/forward unit
interface hazard_tnew_pipe_if #(
  parameter int REG_W = hazard_tnew_pipe_pkg::REG_W,
  parameter int TNEW_W = hazard_tnew_pipe_pkg::TNEW_W,
  parameter int CNT_W = 32
);
  logic stall_d;
  logic clr_e;
  logic [REG_W-1:0] rs_d;
  logic [REG_W-1:0] rt_d;
  logic [REG_W-1:0] write_reg_d;
  logic reg_write_d;
  logic [TNEW_W-1:0] t_new_d;
  logic [REG_W-1:0] rs_e;
  logic [REG_W-1:0] rt_e;
  logic [REG_W-1:0] rt_m;
  logic [REG_W-1:0] write_reg_e;
  logic [REG_W-1:0] write_reg_m;
  logic [REG_W-1:0] write_reg_w;
  logic reg_write_e;
  logic reg_write_m;
  logic reg_write_w;
  logic [TNEW_W-1:0] t_new_e;
  logic [TNEW_W-1:0] t_new_m;
  logic [TNEW_W-1:0] t_new_w;
  logic [CNT_W-1:0] stall_cnt;
  modport master (
    input stall_d, clr_e, rs_d, rt_d, write_reg_d, reg_write_d, t_new_d,
    output rs_e, rt_e, rt_m, write_reg_e, write_reg_m, write_reg_w,
    output reg_write_e, reg_write_m, reg_write_w, t_new_e, t_new_m, t_new_w, stall_cnt
  );
  modport slave (
    output stall_d, clr_e, rs_d, rt_d, write_reg_d, reg_write_d, t_new_d,
    input rs_e, rt_e, rt_m, write_reg_e, write_reg_m, write_reg_w,
    input reg_write_e, reg_write_m, reg_write_w, t_new_e, t_new_m, t_new_w, stall_cnt
  );
endinterface

// File: rtl/hazard_tnew_pipe_tnew_stage_reg.sv
// tnew_stage_reg: one pipeline slice of write-back tags with bubble insert and optional Tnew ageing
module tnew_stage_reg
  import hazard_tnew_pipe_pkg::*;
#(
  parameter bit DEC = 1'b0
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   bubble,
  input  stage_t src,
  output stage_t q
);
  // capture the upstream slice, or a bubble; ageing saturates at zero
  always_ff @(posedge clk or negedge reset)
    if (!reset) q <= BUBBLE;
    else q <= bubble ? BUBBLE : stage_t'{write_reg: src.write_reg, reg_write: src.reg_write,
                                         t_new: DEC ? tnew_age(src.t_new) : src.t_new};
endmodule

// File: rtl/hazard_tnew_pipe.sv
// hazard_tnew_pipe: carries reg-use/write-back tags through E/M/W; optional stall counter via HAZ_STALL_CNT_EN
module hazard_tnew_pipe
  import hazard_tnew_pipe_pkg::*;
#(
  parameter int REG_W = hazard_tnew_pipe_pkg::REG_W,
  parameter int TNEW_W = hazard_tnew_pipe_pkg::TNEW_W,
  parameter int CNT_W = 32
) (
  input logic clk,
  input logic reset,
  hazard_tnew_pipe_if.master bus
);
  logic bubble_e;
  stage_t d_entry, e, m, w;
  logic [REG_W-1:0] rs_q, rt_q, rt_m_q;
  // a stalled or redirected D slot enters E as a bubble; $0 never counts as a write
  always_comb begin
    bubble_e = bus.stall_d | bus.clr_e;
    d_entry = stage_t'{write_reg: bus.write_reg_d,
                       reg_write: bus.reg_write_d && (bus.write_reg_d != '0),
                       t_new: bus.t_new_d};
  end
  tnew_stage_reg #(.DEC(1'b0)) u_e (.clk(clk), .reset(reset), .bubble(bubble_e), .src(d_entry), .q(e));
  tnew_stage_reg #(.DEC(1'b1)) u_m (.clk(clk), .reset(reset), .bubble(1'b0), .src(e), .q(m));
  tnew_stage_reg #(.DEC(1'b1)) u_w (.clk(clk), .reset(reset), .bubble(1'b0), .src(m), .q(w));
  // source indices follow E entry; rt moves on to M for store-data forwarding
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      rs_q <= '0;
      rt_q <= '0;
      rt_m_q <= '0;
    end else begin
      rs_q <= bubble_e ? '0 : bus.rs_d;
      rt_q <= bubble_e ? '0 : bus.rt_d;
      rt_m_q <= rt_q;
    end
  assign bus.rs_e = rs_q;
  assign bus.rt_e = rt_q;
  assign bus.rt_m = rt_m_q;
  assign bus.write_reg_e = e.write_reg;
  assign bus.write_reg_m = m.write_reg;
  assign bus.write_reg_w = w.write_reg;
  assign bus.reg_write_e = e.reg_write;
  assign bus.reg_write_m = m.reg_write;
  assign bus.reg_write_w = w.reg_write;
  assign bus.t_new_e = e.t_new;
  assign bus.t_new_m = m.t_new;
  assign bus.t_new_w = w.t_new;
`ifdef HAZ_STALL_CNT_EN
  logic [CNT_W-1:0] cnt;
  // count stall edges, holding at all-ones
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt <= '0;
    else if (bus.stall_d && cnt != '1) cnt <= cnt + 1'b1;
  assign bus.stall_cnt = cnt;
`else
  assign bus.stall_cnt = '0;
`endif
endmodule

// File: tb/tb_hazard_tnew_pipe.sv
// tb_hazard_tnew_pipe: table-driven check of E/M/W tag transport plus reset, stall and counter sequences
module tb_hazard_tnew_pipe;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  hazard_tnew_pipe_if bus ();
  hazard_tnew_pipe dut (.clk(clk), .reset(reset), .bus(bus));
`ifdef HAZ_STALL_CNT_EN
  hazard_tnew_pipe_if #(.CNT_W(3)) bus3 ();
  hazard_tnew_pipe #(.CNT_W(3)) dut3 (.clk(clk), .reset(reset), .bus(bus3));
  initial begin
    bus3.stall_d = 1'b1;
    bus3.clr_e = 1'b0;
    bus3.rs_d = '0;
    bus3.rt_d = '0;
    bus3.write_reg_d = '0;
    bus3.reg_write_d = 1'b0;
    bus3.t_new_d = '0;
  end
`endif
  typedef struct {
    int st, cl, rs, rt, wr, rw, tn;
    int ers, ert, ewr, erw, etn;
    int mrt, mwr, mrw, mtn;
    int wwr, wrw, wtn;
  } vec_t;
  vec_t tbl [12];
  vec_t z;
  int total = 0;
  int bad = 0;

  task automatic chk(input string n, input int a, input int e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", n, a, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    bus.stall_d = 1'(v.st);
    bus.clr_e = 1'(v.cl);
    bus.rs_d = 5'(v.rs);
    bus.rt_d = 5'(v.rt);
    bus.write_reg_d = 5'(v.wr);
    bus.reg_write_d = 1'(v.rw);
    bus.t_new_d = 2'(v.tn);
  endtask

  task automatic chk_out(input string t, input vec_t v);
    chk({t, ".rs_e"}, int'(bus.rs_e), v.ers);
    chk({t, ".rt_e"}, int'(bus.rt_e), v.ert);
    chk({t, ".write_reg_e"}, int'(bus.write_reg_e), v.ewr);
    chk({t, ".reg_write_e"}, int'(bus.reg_write_e), v.erw);
    chk({t, ".t_new_e"}, int'(bus.t_new_e), v.etn);
    chk({t, ".rt_m"}, int'(bus.rt_m), v.mrt);
    chk({t, ".write_reg_m"}, int'(bus.write_reg_m), v.mwr);
    chk({t, ".reg_write_m"}, int'(bus.reg_write_m), v.mrw);
    chk({t, ".t_new_m"}, int'(bus.t_new_m), v.mtn);
    chk({t, ".write_reg_w"}, int'(bus.write_reg_w), v.wwr);
    chk({t, ".reg_write_w"}, int'(bus.reg_write_w), v.wrw);
    chk({t, ".t_new_w"}, int'(bus.t_new_w), v.wtn);
  endtask

  initial begin
    z = '{default: 0};
    //          st cl rs rt wr rw tn   ers ert ewr erw etn  mrt mwr mrw mtn  wwr wrw wtn
    tbl[0]  = '{0, 0, 1, 8, 8, 1, 2,   1, 8, 8, 1, 2,   0, 0, 0, 0,   0, 0, 0};
    tbl[1]  = '{0, 0, 8, 2, 9, 1, 1,   8, 2, 9, 1, 1,   8, 8, 1, 1,   0, 0, 0};
    tbl[2]  = '{1, 0, 3, 4, 10, 1, 0,  0, 0, 0, 0, 0,   2, 9, 1, 0,   8, 1, 0};
    tbl[3]  = '{0, 0, 5, 6, 0, 1, 1,   5, 6, 0, 0, 1,   0, 0, 0, 0,   9, 1, 0};
    tbl[4]  = '{0, 1, 7, 7, 11, 1, 2,  0, 0, 0, 0, 0,   6, 0, 0, 0,   0, 0, 0};
    tbl[5]  = '{1, 1, 1, 2, 12, 1, 1,  0, 0, 0, 0, 0,   0, 0, 0, 0,   0, 0, 0};
    tbl[6]  = '{0, 0, 3, 13, 14, 0, 0, 3, 13, 14, 0, 0, 0, 0, 0, 0,   0, 0, 0};
    tbl[7]  = '{0, 0, 0, 0, 31, 1, 0,  0, 0, 31, 1, 0,  13, 14, 0, 0, 0, 0, 0};
    tbl[8]  = '{0, 0, 31, 15, 15, 1, 2, 31, 15, 15, 1, 2, 0, 31, 1, 0, 14, 0, 0};
    tbl[9]  = '{0, 0, 2, 3, 16, 1, 3,  2, 3, 16, 1, 3,  15, 15, 1, 1, 31, 1, 0};
    tbl[10] = '{1, 0, 9, 9, 9, 1, 1,   0, 0, 0, 0, 0,   3, 16, 1, 2,  15, 1, 0};
    tbl[11] = '{1, 0, 9, 9, 9, 1, 1,   0, 0, 0, 0, 0,   0, 0, 0, 0,   16, 1, 1};
    drive(z);
    for (int i = 0; i < 3; i++) begin
      bus.stall_d = 1'($urandom);
      bus.clr_e = 1'b0;
      bus.rs_d = 5'($urandom);
      bus.rt_d = 5'($urandom);
      bus.write_reg_d = 5'($urandom_range(1, 31));
      bus.reg_write_d = 1'b1;
      bus.t_new_d = 2'($urandom);
      step();
      chk_out($sformatf("reset%0d", i), z);
      chk("reset.stall_cnt", int'(bus.stall_cnt), 0);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i]);
      step();
      chk_out($sformatf("vec%0d", i), tbl[i]);
    end
`ifdef HAZ_STALL_CNT_EN
    chk("table.stall_cnt", int'(bus.stall_cnt), 4);
`else
    chk("table.stall_cnt", int'(bus.stall_cnt), 0);
`endif
    drive('{st: 0, cl: 0, rs: 0, rt: 20, wr: 20, rw: 1, tn: 2, default: 0});
    step();
    chk("lw.write_reg_e", int'(bus.write_reg_e), 20);
    chk("lw.t_new_e", int'(bus.t_new_e), 2);
    drive('{st: 1, cl: 0, rs: 20, rt: 4, wr: 9, rw: 1, tn: 1, default: 0});
    step();
    chk("stall1.write_reg_e", int'(bus.write_reg_e), 0);
    chk("stall1.reg_write_e", int'(bus.reg_write_e), 0);
    chk("stall1.write_reg_m", int'(bus.write_reg_m), 20);
    chk("stall1.t_new_m", int'(bus.t_new_m), 1);
    step();
    chk("stall2.write_reg_e", int'(bus.write_reg_e), 0);
    chk("stall2.t_new_e", int'(bus.t_new_e), 0);
    chk("stall2.write_reg_w", int'(bus.write_reg_w), 20);
    chk("stall2.reg_write_w", int'(bus.reg_write_w), 1);
    chk("stall2.t_new_w", int'(bus.t_new_w), 0);
    bus.stall_d = 1'b0;
    step();
    chk("release.write_reg_e", int'(bus.write_reg_e), 9);
    chk("release.reg_write_e", int'(bus.reg_write_e), 1);
    chk("release.t_new_e", int'(bus.t_new_e), 1);
    chk("release.rs_e", int'(bus.rs_e), 20);
    #2;
    reset = 1'b0;
    #1;
    chk_out("async", z);
    chk("async.stall_cnt", int'(bus.stall_cnt), 0);
`ifdef HAZ_STALL_CNT_EN
    chk("async.stall_cnt3", int'(bus3.stall_cnt), 0);
`endif
    @(negedge clk);
    reset = 1'b1;
    drive(tbl[0]);
    step();
    chk_out("post_reset", tbl[0]);
    bus.stall_d = 1'b1;
    for (int i = 0; i < 5; i++) step();
    bus.stall_d = 1'b0;
    bus.clr_e = 1'b1;
    step();
    bus.clr_e = 1'b0;
`ifdef HAZ_STALL_CNT_EN
    chk("cnt5.stall_cnt", int'(bus.stall_cnt), 5);
    for (int i = 0; i < 4; i++) step();
    chk("sat.stall_cnt3", int'(bus3.stall_cnt), 7);
`else
    chk("cnt5.stall_cnt", int'(bus.stall_cnt), 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
